// File: rtl/node_tx_queue_if.sv
// Bus between a node core / interposer arbiter and the node transmit queue.
// The drop strobe exists only when NODE_TX_QUEUE_TIMEOUT_EN is defined.
interface node_tx_queue_if #(
   parameter int NODE_COUNT_DIGIT    = 3,
   parameter int ACTUAL_MESSAGE_SIZE = 16,
   parameter int MSG_SIZE            = ACTUAL_MESSAGE_SIZE + 2*NODE_COUNT_DIGIT,
   parameter int DEPTH_DIGIT         = 2
) ();
   logic                           in_valid;
   logic [NODE_COUNT_DIGIT-1:0]    in_dest;
   logic [ACTUAL_MESSAGE_SIZE-1:0] in_data;
   logic                           in_ready;
   logic [NODE_COUNT_DIGIT:0]      req_out;
   logic                           grant_send;
   logic [MSG_SIZE-1:0]            msg_out;
   logic                           msg_valid;
   logic [DEPTH_DIGIT:0]           occupancy;
   logic                           err_grant;
`ifdef NODE_TX_QUEUE_TIMEOUT_EN
   logic                           drop;
`endif

   // core/arbiter side
   modport master (
      output in_valid, in_dest, in_data, grant_send,
      input  in_ready, req_out, msg_out, msg_valid, occupancy, err_grant
`ifdef NODE_TX_QUEUE_TIMEOUT_EN
      , input drop
`endif
   );

   // queue side
   modport slave (
      input  in_valid, in_dest, in_data, grant_send,
      output in_ready, req_out, msg_out, msg_valid, occupancy, err_grant
`ifdef NODE_TX_QUEUE_TIMEOUT_EN
      , output drop
`endif
   );
endinterface

// File: rtl/node_tx_queue.sv
// Node transmit queue: circular FIFO of {dest, payload} entries feeding the
// interposer arbiter through a request/grant handshake. Messages framed as
// {src, dest, payload}.
// Optional: NODE_TX_QUEUE_TIMEOUT_EN adds a grant-wait timeout that discards
// the head entry and pulses bus.drop.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | queue empty (or just drained), no request outstanding
// ST_REQUEST | requesting the arbiter for the head entry's destination
// ST_SEND    | msg_valid high, head entry popped at the end of this cycle
module node_tx_queue #(
   parameter int NODE_NUMBER         = 0,
   parameter int NODE_COUNT          = 8,
   parameter int NODE_COUNT_DIGIT    = 3,
   parameter int ACTUAL_MESSAGE_SIZE = 16,
   parameter int MSG_SIZE            = ACTUAL_MESSAGE_SIZE + 2*NODE_COUNT_DIGIT,
   parameter int DEPTH_DIGIT         = 2
) (
   input logic           clk,
   input logic           reset,
   node_tx_queue_if.slave bus
);
   localparam int DEPTH = 2**DEPTH_DIGIT;
   localparam logic [NODE_COUNT_DIGIT-1:0] SRC = NODE_COUNT_DIGIT'(NODE_NUMBER % NODE_COUNT);
   localparam logic [DEPTH_DIGIT:0] FULL = (DEPTH_DIGIT+1)'(DEPTH);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_REQUEST = 2'd1;
   localparam logic [1:0] ST_SEND    = 2'd2;

   logic [NODE_COUNT_DIGIT-1:0]    dest_mem [DEPTH];
   logic [ACTUAL_MESSAGE_SIZE-1:0] data_mem [DEPTH];
   logic [DEPTH_DIGIT-1:0]         wr_ptr;
   logic [DEPTH_DIGIT-1:0]         rd_ptr;
   logic [DEPTH_DIGIT:0]           occupancy;
   logic [DEPTH_DIGIT:0]           occ_nx;
   logic [1:0]                     state;
   logic [1:0]                     state_nx;
   logic                           msg_valid;
   logic [MSG_SIZE-1:0]            msg_out;
   logic                           err_grant;
   logic                           in_ready;
   logic                           push;
   logic                           pop;
   logic                           launch;
   logic                           timeout_fire;
   logic [NODE_COUNT_DIGIT-1:0]    head_dest;
   logic [ACTUAL_MESSAGE_SIZE-1:0] head_data;

   // Full blocks the offer even when a pop would free a slot this cycle;
   // messages addressed to ourselves complete the handshake but are not stored.
   assign in_ready  = (occupancy != FULL);
   assign push      = bus.in_valid && in_ready && (bus.in_dest != SRC);
   assign head_dest = dest_mem[rd_ptr];
   assign head_data = data_mem[rd_ptr];
   assign launch    = (state == ST_REQUEST) && bus.grant_send;
   assign pop       = (state == ST_SEND) || timeout_fire;
   assign occ_nx    = occupancy + (DEPTH_DIGIT+1)'(push) - (DEPTH_DIGIT+1)'(pop);

`ifdef NODE_TX_QUEUE_TIMEOUT_EN
   // 254 down to 0 spans 255 grantless REQUEST cycles
   localparam logic [7:0] TMO_LOAD = 8'd254;
   logic [7:0] tmo_cnt;
   logic       drop;

   assign timeout_fire = (state == ST_REQUEST) && !bus.grant_send && (tmo_cnt == 8'd0);

   // grant-wait down-counter; reloads whenever REQUEST is left or the head is discarded
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         tmo_cnt <= TMO_LOAD;
         drop    <= 1'b0;
      end else begin
         drop <= timeout_fire;
         if ((state == ST_REQUEST) && !bus.grant_send && !timeout_fire)
            tmo_cnt <= tmo_cnt - 8'd1;
         else
            tmo_cnt <= TMO_LOAD;
      end
   end

   assign bus.drop = drop;
`else
   assign timeout_fire = 1'b0;
`endif

   // next-state decode; after a pop the decision uses the post-pop occupancy
   always_comb begin
      state_nx = state;
      case (state)
         ST_IDLE:    if (occupancy != '0) state_nx = ST_REQUEST;
         ST_REQUEST: begin
            if (bus.grant_send)
               state_nx = ST_SEND;
            else if (timeout_fire)
               state_nx = (occ_nx != '0) ? ST_REQUEST : ST_IDLE;
         end
         ST_SEND:    state_nx = (occ_nx != '0) ? ST_REQUEST : ST_IDLE;
         default:    state_nx = ST_IDLE;
      endcase
   end

   // control state, pointers, framed output register and sticky grant error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         occupancy <= '0;
         msg_valid <= 1'b0;
         msg_out   <= '0;
         err_grant <= 1'b0;
      end else begin
         state     <= state_nx;
         occupancy <= occ_nx;
         msg_valid <= launch;
         if (push) wr_ptr <= wr_ptr + DEPTH_DIGIT'(1);
         if (pop)  rd_ptr <= rd_ptr + DEPTH_DIGIT'(1);
         if (launch) msg_out <= MSG_SIZE'({SRC, head_dest, head_data});
         if (bus.grant_send && (state != ST_REQUEST)) err_grant <= 1'b1;
      end
   end

   // entry storage; contents are only read once written, so no reset needed
   always_ff @(posedge clk) begin
      if (push) begin
         dest_mem[wr_ptr] <= bus.in_dest;
         data_mem[wr_ptr] <= bus.in_data;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.req_out   = (state == ST_REQUEST) ? {1'b1, head_dest} : '0;
   assign bus.msg_out   = msg_out;
   assign bus.msg_valid = msg_valid;
   assign bus.occupancy = occupancy;
   assign bus.err_grant = err_grant;
endmodule
